// File: rtl/forward_queue.sv
`default_nettype none
// ============================================================================
// Module   : forward_queue
// Purpose  : Register-array FIFO with ready/ack handshakes, synchronous flush
//            and optional push-while-full when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module forward_queue #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter bit FAST  = 1'b1,
    localparam int NW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          src_rdy,
    output logic          src_ack,
    input  logic [DW-1:0] src_data,
    output logic          dst_rdy,
    input  logic          dst_ack,
    output logic [DW-1:0] dst_data,
    input  logic          flush,
    output logic [NW-1:0] o_n,
    output logic          o_full,
    output logic          o_empty
);

    localparam logic [PW-1:0] c_last = PW'(DEPTH - 1);
    localparam logic [NW-1:0] c_depth = NW'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [NW-1:0] r_n;

    logic w_push;
    logic w_pop;

    assign o_n     = r_n;
    assign o_full  = (r_n == c_depth);
    assign o_empty = (r_n == '0);
    assign dst_rdy = !o_empty;
    assign dst_data = r_mem[r_rp];

    // A full queue may still accept when the head leaves in the same cycle.
    assign src_ack = src_rdy && !flush && (!o_full || (FAST && dst_ack && dst_rdy));
    assign w_push  = src_ack;
    assign w_pop   = dst_rdy && dst_ack && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp <= '0;
            r_rp <= '0;
            r_n  <= '0;
        end else if (flush) begin
            r_wp <= '0;
            r_rp <= '0;
            r_n  <= '0;
        end else begin
            if (w_push) begin
                r_wp <= (r_wp == c_last) ? '0 : r_wp + PW'(1);
            end
            if (w_pop) begin
                r_rp <= (r_rp == c_last) ? '0 : r_rp + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_n <= r_n + NW'(1);
                2'b01:   r_n <= r_n - NW'(1);
                default: r_n <= r_n;
            endcase
        end
    end

    // Storage is cleared by reset only; flush leaves the contents in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wp] <= src_data;
        end
    end

endmodule
`default_nettype wire

// File: doc/forward_queue.md
FORWARD_QUEUE -- requirements
Module: forward_queue

Interface
REQ-001 SHALL have parameter DW, default 8: payload width in bits, legal range 1 or more.
REQ-002 SHALL have parameter DEPTH, default 4: number of storage entries, legal range 2 or more; DEPTH need not be a power of two.
REQ-003 SHALL have parameter bit FAST, default 1: when 1, a push is accepted while full provided a pop occurs in the same cycle.
REQ-004 SHALL have derived width NW = $clog2(DEPTH+1) and pointer width PW = $clog2(DEPTH).
REQ-005 clk  input  1  rising-edge clock; the only clock.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 src_rdy  input  1  producer has valid src_data.
REQ-008 src_ack  output  1  entry accepted this cycle.
REQ-009 src_data  input  DW  payload in.
REQ-010 dst_rdy  output  1  head entry valid.
REQ-011 dst_ack  input  1  consumer takes head this cycle.
REQ-012 dst_data  output  DW  head entry payload.
REQ-013 flush  input  1  synchronous clear of all entries.
REQ-014 o_n  output  NW  current occupancy, 0..DEPTH.
REQ-015 o_full  output  1  o_n == DEPTH.
REQ-016 o_empty  output  1  o_n == 0.

Function
REQ-017 SHALL store entries in a DEPTH x DW register array addressed by write pointer wp and read pointer rp, each PW bits wide.
REQ-018 SHALL drive src_ack = src_rdy && !flush && (!o_full || (FAST && dst_ack && dst_rdy)), purely combinationally.
REQ-019 SHALL drive dst_rdy = !o_empty, derived from registered state only; there is no combinational path from src_rdy to dst_rdy.
REQ-020 SHALL drive dst_data = mem[rp] combinationally; dst_data is don't-care while dst_rdy = 0.
REQ-021 SHALL treat pop = dst_rdy && dst_ack && !flush; a dst_ack with dst_rdy = 0 SHALL have no effect.
REQ-022 SHALL, on push (src_ack), write src_data to mem[wp] at the clock edge and advance wp.
REQ-023 SHALL, on pop, advance rp.
REQ-024 SHALL wrap both pointers from DEPTH-1 to 0 rather than by natural overflow.
REQ-025 SHALL set latency from src_ack to dst_rdy to exactly 1 cycle when the queue is empty.
REQ-026 SHALL update o_n as follows:
- push only: +1
- pop only: -1
- push and pop together: unchanged
- neither: unchanged
REQ-027 SHALL make o_n, o_full and o_empty registered or decoded from registered state only; o_n never exceeds DEPTH and never underflows.
REQ-028 SHALL, on simultaneous push and pop with o_n == 1, present the new entry as head on the next cycle with o_n staying at 1.
REQ-029 SHALL, with FAST = 0, hold src_ack at 0 whenever o_full = 1, regardless of dst_ack.
REQ-030 SHALL, on flush = 1, set o_n, wp and rp to 0 at the next edge; any push or pop in that cycle is suppressed and mem contents are left unchanged.
REQ-031 SHALL preserve FIFO order: entries leave in exactly the order they were accepted.

Reset
REQ-032 SHALL, while rst = 0, asynchronously force:
- o_n = 0, wp = 0, rp = 0
- dst_rdy = 0, o_empty = 1, o_full = 0
- all mem entries = 0, so dst_data = 0
REQ-033 SHALL, when reset is asserted mid-operation, discard all stored entries; src_ack may be 1 combinationally during reset, but no push is stored.
REQ-034 SHALL resume normal operation on the first rising clk edge after rst returns to 1.

Verification
REQ-035 Fill/drain, DEPTH=4, DW=8: push 0x11,0x22,0x33,0x44 with dst_ack = 0 -> o_full = 1 and src_ack = 0 for a 5th src_rdy; then ack 4 times -> outputs 0x11..0x44 in order, then o_empty = 1.
REQ-036 FAST=1 while full: src_rdy = 1, dst_ack = 1 in the same cycle -> src_ack = 1, o_n stays at 4. FAST=0, same stimulus -> src_ack = 0 and o_n = 3 next cycle.
REQ-037 Wrap with DEPTH=3: stream 10 values with src_rdy and dst_ack held high -> output order matches input, pointers wrap 2 -> 0, o_n never exceeds 3.
REQ-038 Flush: o_n = 3 with flush and src_rdy both 1 -> src_ack = 0, next cycle o_n = 0 and dst_rdy = 0; the next push appears one cycle later at dst_data.
REQ-039 Async reset mid-stream: drop rst between clock edges with o_n = 2 -> o_n = 0 and dst_rdy = 0 immediately, with no clock edge needed.
REQ-040 Randomised rdy/ack against a scoreboard model for 10k cycles -> no loss, duplication or reordering; o_n always equals the model count.
